// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter and its helpers.
package clk_period_meter_pkg;

    // Measurement state: waiting for the first edge, or timing a period.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // All-ones value of a counter of the given width (2^width - 1).
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchronizer plus a delay flop for edge decoding of a slow,
// asynchronous clock-like signal. rise/fall come only from registers.
module clk_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Synchronizer chain and one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_dly;
    assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock in clk cycles, flags lock
// when consecutive periods fall within tolerance of the expected value, and
// flags a sticky timeout when no rising edge arrives before the counter tops out.
// Optional macro CLK_PERIOD_METER_DUTY_EN adds a high_time output.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 6,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam int               MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_C = MATCH_W'(LOCK_CNT);

    logic w_in_sync;
    logic w_rise;
    logic w_fall;

    state_t             r_state,  w_state_next;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_next;
    logic [CNT_W-1:0]   r_period, w_period_next;
    logic               r_pv,     w_pv_next;
    logic [MATCH_W-1:0] r_match,  w_match_next;
    logic               r_locked, w_locked_next;
    logic               r_timeout, w_timeout_next;
    logic [CNT_W-1:0]   w_diff;
    logic               w_in_tol;

    clk_edge_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (in_clk),
        .o_sync  (w_in_sync),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_pv      <= 1'b0;
            r_match   <= '0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_period  <= w_period_next;
            r_pv      <= w_pv_next;
            r_match   <= w_match_next;
            r_locked  <= w_locked_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Next-state: period capture on rise, lock tracking, timeout on saturation.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_period_next  = r_period;
        w_pv_next      = 1'b0;
        w_match_next   = r_match;
        w_locked_next  = r_locked;
        w_timeout_next = r_timeout;
        // Unsigned absolute difference, ordered so it never wraps.
        w_diff   = (r_cnt >= EXP_C) ? (r_cnt - EXP_C) : (EXP_C - r_cnt);
        w_in_tol = (w_diff <= TOL_C);
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_rise) begin
                    w_cnt_next   = CNT_W'(1);
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_period_next = r_cnt;
                    w_pv_next     = 1'b1;
                    w_cnt_next    = CNT_W'(1);
                    if (w_in_tol) begin
                        if (r_match < LOCK_C) begin
                            w_match_next = r_match + MATCH_W'(1);
                        end
                        if (r_match >= LOCK_C - MATCH_W'(1)) begin
                            w_locked_next = 1'b1;
                        end
                    end else begin
                        w_match_next  = '0;
                        w_locked_next = 1'b0;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    // Counter already topped out and still no edge: give up.
                    w_timeout_next = 1'b1;
                    w_locked_next  = 1'b0;
                    w_match_next   = '0;
                    w_cnt_next     = '0;
                    w_state_next   = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rise_pulse   = w_rise;
    assign fall_pulse   = w_fall;
    assign period       = r_period;
    assign period_valid = r_pv;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_high_time;

    // High-phase counter restarts at each rise; latched into high_time on fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_high_cnt  <= '0;
            r_high_time <= '0;
        end else begin
            if (w_rise) begin
                r_high_cnt <= CNT_W'(1);
            end else if (w_in_sync && (r_high_cnt != CNT_MAX)) begin
                r_high_cnt <= r_high_cnt + CNT_W'(1);
            end
            if (w_fall && (r_state == MEASURE)) begin
                r_high_time <= r_high_cnt;
            end
        end
    end

    assign high_time = r_high_time;
`else
    logic w_unused_in_sync;
    assign w_unused_in_sync = w_in_sync;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: three instances (defaults, TOL=1,
// CNT_W=4) share clk and rst; each has its own in_clk.
module tb_clk_period_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] in_clk_v = 3'b000;

    wire [2:0]  rise_v;
    wire [2:0]  fall_v;
    wire [2:0]  pv_v;
    wire [2:0]  locked_v;
    wire [2:0]  timeout_v;
    wire [15:0] p0;
    wire [15:0] p1;
    wire [3:0]  p2;
`ifdef CLK_PERIOD_METER_DUTY_EN
    wire [15:0] ht0;
    wire [15:0] ht1;
    wire [3:0]  ht2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clk_period_meter dut (
        .clk(clk), .rst(rst), .in_clk(in_clk_v[0]),
        .rise_pulse(rise_v[0]), .fall_pulse(fall_v[0]), .period(p0),
        .period_valid(pv_v[0]), .locked(locked_v[0]), .timeout(timeout_v[0])
`ifdef CLK_PERIOD_METER_DUTY_EN
        , .high_time(ht0)
`endif
    );

    clk_period_meter #(.TOL(1)) dut_t (
        .clk(clk), .rst(rst), .in_clk(in_clk_v[1]),
        .rise_pulse(rise_v[1]), .fall_pulse(fall_v[1]), .period(p1),
        .period_valid(pv_v[1]), .locked(locked_v[1]), .timeout(timeout_v[1])
`ifdef CLK_PERIOD_METER_DUTY_EN
        , .high_time(ht1)
`endif
    );

    clk_period_meter #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_clk(in_clk_v[2]),
        .rise_pulse(rise_v[2]), .fall_pulse(fall_v[2]), .period(p2),
        .period_valid(pv_v[2]), .locked(locked_v[2]), .timeout(timeout_v[2])
`ifdef CLK_PERIOD_METER_DUTY_EN
        , .high_time(ht2)
`endif
    );

    function automatic logic [15:0] period_of(input int k);
        case (k)
            0:       return p0;
            1:       return p1;
            default: return {12'd0, p2};
        endcase
    endfunction

    // Monitor bookkeeping, sampled on the falling edge.
    int          pv_count [3]    = '{0, 0, 0};
    int          fall_count [3]  = '{0, 0, 0};
    logic [15:0] last_period [3] = '{16'd0, 16'd0, 16'd0};
    logic        last_locked [3] = '{1'b0, 1'b0, 1'b0};
    logic        last_lag_ok [3] = '{1'b0, 1'b0, 1'b0};
    logic        rise_prev [3]   = '{1'b0, 1'b0, 1'b0};
    logic        both_seen       = 1'b0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pv_v[k]) begin
                pv_count[k]    <= pv_count[k] + 1;
                last_period[k] <= period_of(k);
                last_locked[k] <= locked_v[k];
                last_lag_ok[k] <= rise_prev[k];
            end
            if (fall_v[k]) fall_count[k] <= fall_count[k] + 1;
            if (rise_v[k] && fall_v[k]) both_seen <= 1'b1;
            rise_prev[k] <= rise_v[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
        $display("check %-18s observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // One in_clk period: rise at a falling clk edge, h cycles high, l low.
    task automatic drive(input int k, input int h, input int l);
        in_clk_v[k] = 1'b1;
        repeat (h) @(negedge clk);
        in_clk_v[k] = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    int snap;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rise",    32'(rise_v[0]), 0);
        check("rst_fall",    32'(fall_v[0]), 0);
        check("rst_period",  32'(p0), 0);
        check("rst_pv",      32'(pv_v[0]), 0);
        check("rst_locked",  32'(locked_v[0]), 0);
        check("rst_timeout", 32'(timeout_v[0]), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Divide-by-6: first rise only starts the measurement.
        drive(0, 3, 3);
        check("first_no_pv", 32'(pv_count[0]), 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 3, 3);
            check("d6_period", 32'(last_period[0]), 6);
            check("d6_pv_lag", 32'(last_lag_ok[0]), 1);
            check("d6_locked", 32'(last_locked[0]), (i == 3) ? 32'd1 : 32'd0);
        end

        // One long period of 8 drops lock, then four 6s re-lock.
        drive(0, 4, 4);
        check("pre8_locked", 32'(last_locked[0]), 1);
        drive(0, 3, 3);
        check("p8_period", 32'(last_period[0]), 8);
        check("p8_unlock", 32'(last_locked[0]), 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 3, 3);
            check("relock_period", 32'(last_period[0]), 6);
            check("relock_locked", 32'(last_locked[0]), (i == 3) ? 32'd1 : 32'd0);
        end

`ifdef CLK_PERIOD_METER_DUTY_EN
        drive(0, 2, 4);
        drive(0, 2, 4);
        check("duty_high_time", 32'(ht0), 2);
        check("duty_period", 32'(last_period[0]), 6);
`endif

        // TOL=1: alternating 5 and 7 locks, an 8 unlocks.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) drive(1, 2, 3);
            else            drive(1, 3, 4);
            if (i == 3) check("tol_not_yet", 32'(last_locked[1]), 0);
        end
        check("tol_period7", 32'(last_period[1]), 7);
        check("tol_locked", 32'(last_locked[1]), 1);
        drive(1, 4, 4);
        check("tol_period5", 32'(last_period[1]), 5);
        drive(1, 2, 3);
        check("tol_period8", 32'(last_period[1]), 8);
        check("tol_unlock", 32'(last_locked[1]), 0);

        // CNT_W=4: lock, then hold in_clk low until timeout.
        for (int i = 0; i < 5; i++) drive(2, 3, 3);
        check("w_locked", 32'(locked_v[2]), 1);
        repeat (4) @(negedge clk);
        check("w_no_timeout", 32'(timeout_v[2]), 0);
        repeat (20) @(negedge clk);
        check("w_timeout", 32'(timeout_v[2]), 1);
        check("w_to_unlock", 32'(locked_v[2]), 0);
        check("w_period_hold", 32'(p2), 6);
        snap = pv_count[2];
        drive(2, 3, 3);
        check("w_restart_no_pv", 32'(pv_count[2] - snap), 0);
        drive(2, 3, 3);
        check("w_restart_pv", 32'(pv_count[2] - snap), 1);
        check("w_restart_period", 32'(last_period[2]), 6);
        check("w_timeout_sticky", 32'(timeout_v[2]), 1);

        // Asynchronous reset in the middle of a measurement.
        in_clk_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_period", 32'(p0), 0);
        check("arst_locked", 32'(locked_v[0]), 0);
        check("arst_pv", 32'(pv_v[0]), 0);
        check("arst_timeout_w", 32'(timeout_v[2]), 0);
        in_clk_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        snap = pv_count[0];
        drive(0, 3, 3);
        check("post_rst_no_pv", 32'(pv_count[0] - snap), 0);
        drive(0, 3, 3);
        check("post_rst_pv", 32'(pv_count[0] - snap), 1);
        check("post_rst_period", 32'(last_period[0]), 6);

        check("rise_fall_excl", 32'(both_seen), 0);
        check("falls_seen", 32'(fall_count[0] != 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receives a slow, divided clock signal (e.g. a divide-by-6 clock from the clock divider chain) on in_clk, asynchronous to clk.
- Synchronizes the signal and detects its edges.
- Measures its period in clk cycles and asserts locked once the period matches the expected divide ratio.
- Sits on the consuming side of the divider chain; used as an on-chip frequency checker and edge-pulse generator for downstream counters.

Parameters:
- CNT_W, 16, width of the period counter and the period output.
- EXP_PERIOD, 6, expected period in clk cycles.
- TOL, 0, allowed absolute deviation from EXP_PERIOD, inclusive.
- LOCK_CNT, 4, consecutive in-tolerance periods required to assert locked (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- in_clk  input  1  measured slow clock, asynchronous to clk
- rise_pulse  output  1  one-cycle pulse per detected rising edge of in_clk
- fall_pulse  output  1  one-cycle pulse per detected falling edge of in_clk
- period  output  CNT_W  last measured period in clk cycles
- period_valid  output  1  one-cycle pulse when period is updated
- locked  output  1  period stable within tolerance
- timeout  output  1  sticky; no rising edge seen within 2^CNT_W-1 cycles

Behaviour:
Reset and clocking:
- Clock is clk, positive edge. Reset rst is asynchronous, active-low.
- Reset values: all outputs 0, synchronizer flops 0, internal counters 0, state IDLE.

Synchronizer and edge detection:
- Two-flop synchronizer gives in_sync. A third flop gives in_d.
- rise = in_sync & ~in_d; fall = ~in_sync & in_d. Both are decoded from registers, with no combinational path from in_clk.
- rise_pulse and fall_pulse drive rise and fall directly. A transition of in_clk sampled at edge k makes the pulse high in the cycle after edge k+1.

State machine (IDLE, MEASURE):
- IDLE: cnt held at 0. On rise: cnt <= 1, go to MEASURE. No period_valid is produced.
- MEASURE, each cycle without rise: cnt <= cnt+1, saturating at 2^CNT_W-1.
- MEASURE, on rise: period <= cnt, period_valid pulses for exactly one cycle (registered, one cycle after rise_pulse), cnt <= 1.
- Result: a divide-by-N source with stable input produces period = N.
- Saturation: if cnt reaches 2^CNT_W-1 with no rise, then timeout <= 1 (sticky until reset), locked <= 0, match count <= 0, state goes to IDLE. period holds its last value.
- A rise in the same cycle cnt would saturate counts as a normal edge, and timeout is not set.

Lock logic, evaluated on each period update:
- In tolerance means |cnt - EXP_PERIOD| <= TOL, computed unsigned with no wrap.
- In tolerance: match count increments, saturating at LOCK_CNT. locked <= 1 when it reaches LOCK_CNT.
- Out of tolerance: match count <= 0 and locked <= 0 in the same cycle period_valid is high.

Other rules:
- rise and fall can never occur in the same cycle.
- in_clk held static leaves the pulse outputs at 0 and leads to timeout.
- Reset asserted mid-measurement: everything returns to reset values immediately. After release, the first rise only starts a measurement.

Optional Feature:
- Macro: CLK_PERIOD_METER_DUTY_EN.
- Defined: adds output high_time (CNT_W bits, reset 0) and a high-phase counter.
  - The counter is cleared to 1 on rise and increments while in_sync is high, saturating.
  - On fall in MEASURE, high_time <= high-phase counter.
  - For a 3-high/3-low divide-by-6 source, high_time = 3.
- Not defined: no high_time port, no high-phase counter. All other behaviour is identical.

Decomposition:
- Shared package: state enum (IDLE, MEASURE) and a saturating-max constant helper (2^CNT_W-1).
- One natural sub-module: clk_edge_sync (two-flop synchronizer plus edge flop, producing in_sync, rise, fall). It is reusable by other blocks that consume divided clocks.

Test Plan:
- Reset release, in_clk from divide-by-6 source (3 clk high, 3 low), defaults -> first rise gives no period_valid; every later rise gives period=6 with period_valid one cycle after rise_pulse; locked=1 on the 4th period_valid.
- Locked at 6, then one period of 8 (EXP=6, TOL=0) -> period=8, locked=0 in the same cycle as period_valid; re-locks after 4 more periods of 6.
- TOL=1, periods alternating 5 and 7 -> locked after 4 updates; a period of 8 clears locked.
- CNT_W=4, in_clk held low after lock -> timeout=1 and locked=0 when cnt reaches 15; state IDLE; period keeps 6; the next rise starts a new measurement without period_valid.
- rst pulsed low mid-period -> all outputs 0 asynchronously; after release the first rise gives no period_valid, and the second gives the correct period.
- With CLK_PERIOD_METER_DUTY_EN defined, divide-by-6 input with 2 high/4 low -> high_time=2, period=6; with the macro undefined, the module elaborates without the high_time port.
